// File: rtl/multi_trip_filter.sv
// multi_trip_filter: per-channel trip filter with sample counting, latched
// trips and first-fault capture (lowest channel index wins a tie).
// Optional feature macro: MULTI_TRIP_TIMESTAMP_EN adds a 32-bit trig counter
// whose value is captured into first_ts when the first trip is recorded.
// Without the macro, first_ts is tied to zero.
module multi_trip_filter #(
  parameter int NCH = 8,
  parameter int CW  = 4,
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           trig,
  input  logic [CW-1:0]  nof_cycle,
  input  logic           mode,
  input  logic [NCH-1:0] mask,
  input  logic           clear,
  input  logic [NCH-1:0] sig_in,
  output logic [NCH-1:0] trip_out,
  output logic           trip_any,
  output logic [IW-1:0]  first_ch,
  output logic           first_valid,
  output logic [31:0]    first_ts
);

  logic [CW-1:0]  cnt_q [NCH];
  logic [CW-1:0]  cnt_d [NCH];
  logic [NCH-1:0] trip_q, trip_d;
  logic           trip_any_q;
  logic [IW-1:0]  first_ch_q, first_ch_d;
  logic           first_valid_q, first_valid_d;
  logic [CW-1:0]  eff_n;
  logic [CW-1:0]  nxt;
  logic [NCH-1:0] new_trips;
  logic [IW-1:0]  low_idx;

`ifdef MULTI_TRIP_TIMESTAMP_EN
  logic [31:0] ts_q, ts_d;
  logic [31:0] first_ts_q, first_ts_d;
`endif

  // Next count and trip state per channel; clear discards the coincident sample.
  always_comb begin
    eff_n = (nof_cycle == '0) ? CW'(1) : nof_cycle;
    nxt   = '0;
    cnt_d = cnt_q;
    trip_d = trip_q;
    if (clear) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_d[i] = '0;
      end
      trip_d = '0;
    end else if (trig) begin
      for (int i = 0; i < NCH; i++) begin
        if (mask[i]) begin
          cnt_d[i] = '0;
        end else if (!trip_q[i]) begin
          if (sig_in[i]) begin
            nxt = (cnt_q[i] == '1) ? cnt_q[i] : cnt_q[i] + 1'b1;
          end else begin
            nxt = mode ? '0 : cnt_q[i];
          end
          cnt_d[i] = nxt;
          if (nxt >= eff_n) begin
            trip_d[i] = 1'b1;
          end
        end
      end
    end
  end

  // First-fault capture: lowest-index newly tripping channel while none is held.
  always_comb begin
    new_trips = trip_d & ~trip_q;
    low_idx   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (new_trips[i]) begin
        low_idx = IW'(i);
      end
    end
    first_ch_d    = first_ch_q;
    first_valid_d = first_valid_q;
    if (clear) begin
      first_ch_d    = '0;
      first_valid_d = 1'b0;
    end else if (!first_valid_q && (new_trips != '0)) begin
      first_ch_d    = low_idx;
      first_valid_d = 1'b1;
    end
  end

`ifdef MULTI_TRIP_TIMESTAMP_EN
  // Trig counter keeps running through clear; the capture takes the post-increment value.
  always_comb begin
    ts_d       = trig ? ts_q + 32'd1 : ts_q;
    first_ts_d = first_ts_q;
    if (clear) begin
      first_ts_d = '0;
    end else if (!first_valid_q && (new_trips != '0)) begin
      first_ts_d = ts_d;
    end
  end
`endif

  // State registers; reset overrides trig and clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
      trip_q        <= '0;
      trip_any_q    <= 1'b0;
      first_ch_q    <= '0;
      first_valid_q <= 1'b0;
`ifdef MULTI_TRIP_TIMESTAMP_EN
      ts_q          <= '0;
      first_ts_q    <= '0;
`endif
    end else begin
      cnt_q         <= cnt_d;
      trip_q        <= trip_d;
      trip_any_q    <= |trip_d;
      first_ch_q    <= first_ch_d;
      first_valid_q <= first_valid_d;
`ifdef MULTI_TRIP_TIMESTAMP_EN
      ts_q          <= ts_d;
      first_ts_q    <= first_ts_d;
`endif
    end
  end

  assign trip_out    = trip_q;
  assign trip_any    = trip_any_q;
  assign first_ch    = first_ch_q;
  assign first_valid = first_valid_q;
`ifdef MULTI_TRIP_TIMESTAMP_EN
  assign first_ts    = first_ts_q;
`else
  assign first_ts    = 32'd0;
`endif

endmodule
